// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment readback path: segment codes,
// the invalid-digit marker, digit (anode) indices and anode sample classes.
package seg7_pkg;

    // Active-low segment codes, bit6 = a ... bit0 = g.
    localparam logic [6:0] SEG_CODE_0 = 7'b0000001;
    localparam logic [6:0] SEG_CODE_1 = 7'b1001111;
    localparam logic [6:0] SEG_CODE_2 = 7'b0010010;
    localparam logic [6:0] SEG_CODE_3 = 7'b0000110;
    localparam logic [6:0] SEG_CODE_4 = 7'b1001100;
    localparam logic [6:0] SEG_CODE_5 = 7'b0100100;
    localparam logic [6:0] SEG_CODE_6 = 7'b0100000;
    localparam logic [6:0] SEG_CODE_7 = 7'b0001111;
    localparam logic [6:0] SEG_CODE_8 = 7'b0000000;
    localparam logic [6:0] SEG_CODE_9 = 7'b0000100;

    // Digit value reported for a code outside the table.
    localparam logic [3:0] SEG_INVALID = 4'hF;

    // Digit index behind each anode; index 0 is the leftmost digit.
    localparam logic [1:0] DIG_THOUSANDS = 2'd0;  // a1
    localparam logic [1:0] DIG_HUNDREDS  = 2'd1;  // a2
    localparam logic [1:0] DIG_TENS      = 2'd2;  // a3
    localparam logic [1:0] DIG_UNITS     = 2'd3;  // a4

    // Classification of one anode sample.
    localparam logic [1:0] ANODE_BLANK   = 2'd0;
    localparam logic [1:0] ANODE_DIGIT   = 2'd1;
    localparam logic [1:0] ANODE_COLLIDE = 2'd2;

    // act[i] is 1 when the anode of digit index i is driven (low on the bus).
    function automatic logic [1:0] anode_class(input logic [3:0] act);
        logic [1:0] cls;
        case (act)
            4'b0000:                            cls = ANODE_BLANK;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: cls = ANODE_DIGIT;
            default:                            cls = ANODE_COLLIDE;
        endcase
        return cls;
    endfunction

    // Index of the single active anode; only meaningful for ANODE_DIGIT.
    function automatic logic [1:0] anode_index(input logic [3:0] act);
        logic [1:0] idx;
        case (act)
            4'b0010: idx = DIG_HUNDREDS;
            4'b0100: idx = DIG_TENS;
            4'b1000: idx = DIG_UNITS;
            default: idx = DIG_THOUSANDS;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment to BCD decode with a validity flag.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       valid
);

    // Table lookup of the active-low segment pattern.
    always_comb begin
        // NOTE: default every output first so no path leaves one unassigned (no latch).
        bcd   = SEG_INVALID;
        valid = 1'b1;
        case (seg)
            SEG_CODE_0: bcd = 4'd0;
            SEG_CODE_1: bcd = 4'd1;
            SEG_CODE_2: bcd = 4'd2;
            SEG_CODE_3: bcd = 4'd3;
            SEG_CODE_4: bcd = 4'd4;
            SEG_CODE_5: bcd = 4'd5;
            SEG_CODE_6: bcd = 4'd6;
            SEG_CODE_7: bcd = 4'd7;
            SEG_CODE_8: bcd = 4'd8;
            SEG_CODE_9: bcd = 4'd9;
            default:    valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Readback of the multiplexed 4-digit display bus: recovers digits per anode,
// assembles scan frames, publishes the number in binary and measures blanking.
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int BLANK_MIN = 4,
    parameter int BLANK_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         led_seg,
    input  logic               a1,
    input  logic               a2,
    input  logic               a3,
    input  logic               a4,
    output logic [3:0]         val1,
    output logic [3:0]         val2,
    output logic [3:0]         val3,
    output logic [3:0]         val4,
    output logic               frame_valid,
    output logic               frame_err,
    output logic [13:0]        value,
    output logic               value_valid,
    output logic               blank,
    output logic [BLANK_W-1:0] blank_len
);

    localparam logic [BLANK_W-1:0] BLANK_MIN_V = BLANK_W'(BLANK_MIN);
    localparam logic [BLANK_W-1:0] BLANK_MAX_V = '1;

    logic [3:0]         dec_bcd;
    logic               dec_valid;
    logic [3:0]         act;
    logic [1:0]         cls;
    logic [1:0]         idx;
    logic [3:0]         seen_nx;
    logic               bad_nx;

    logic [3:0]         shadow_q [4];
    logic [3:0]         shadow_d [4];
    logic [3:0]         val_q    [4];
    logic [3:0]         val_d    [4];
    logic [3:0]         seen_q, seen_d;
    logic               bad_q, bad_d;
    logic               frame_valid_q, frame_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [13:0]        value_q, value_d;
    logic               value_valid_q, value_valid_d;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic               blank_q, blank_d;
    logic [BLANK_W-1:0] blank_len_q, blank_len_d;

    seg7_to_bcd u_dec (
        .seg   (led_seg),
        .bcd   (dec_bcd),
        .valid (dec_valid)
    );

    // act bit i set when the anode of digit index i is active (bus low).
    assign act = ~{a4, a3, a2, a1};
    assign cls = anode_class(act);
    assign idx = anode_index(act);

    // Frame assembly, blank measurement and binary conversion next-state.
    always_comb begin
        shadow_d      = shadow_q;
        val_d         = val_q;
        seen_d        = seen_q;
        bad_d         = bad_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        blank_cnt_d   = blank_cnt_q;
        blank_d       = blank_q;
        blank_len_d   = blank_len_q;
        seen_nx       = seen_q | (4'b0001 << idx);
        bad_nx        = bad_q | ~dec_valid;

        case (cls)
            ANODE_DIGIT: begin
                shadow_d[idx] = dec_bcd;
                // Completion is judged on the updated seen/bad so the closing
                // digit itself can both finish and spoil the frame.
                if (seen_nx == 4'b1111) begin
                    if (!bad_nx) begin
                        val_d         = shadow_d;
                        frame_valid_d = 1'b1;
                    end else begin
                        frame_err_d   = 1'b1;
                    end
                    seen_d = 4'b0000;
                    bad_d  = 1'b0;
                end else begin
                    seen_d = seen_nx;
                    bad_d  = bad_nx;
                end
            end
            ANODE_COLLIDE: begin
                frame_err_d = 1'b1;
                seen_d      = 4'b0000;
                bad_d       = 1'b0;
                shadow_d    = '{default: 4'd0};
            end
            default: ;  // blank: frame state is held across flash-off gaps
        endcase

        if (cls == ANODE_BLANK) begin
            if (blank_cnt_q != BLANK_MAX_V) begin
                blank_cnt_d = blank_cnt_q + 1'b1;
            end
            blank_d = (blank_cnt_d >= BLANK_MIN_V);
        end else begin
            if (blank_cnt_q >= BLANK_MIN_V) begin
                blank_len_d = blank_cnt_q;
            end
            blank_cnt_d = '0;
            blank_d     = 1'b0;
        end

        // Binary value follows one cycle behind the digit registers.
        value_valid_d = frame_valid_q;
        value_d       = value_q;
        if (frame_valid_q) begin
            value_d = 14'(val_q[0]) * 14'd1000 + 14'(val_q[1]) * 14'd100
                    + 14'(val_q[2]) * 14'd10   + 14'(val_q[3]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shadow and digit arrays are only 4x4 bits, so they are reset
            // like ordinary flops rather than left as an unreset memory.
            shadow_q      <= '{default: 4'd0};
            val_q         <= '{default: 4'd0};
            seen_q        <= 4'b0000;
            bad_q         <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            value_q       <= 14'd0;
            value_valid_q <= 1'b0;
            blank_cnt_q   <= '0;
            blank_q       <= 1'b0;
            blank_len_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            shadow_q      <= shadow_d;
            val_q         <= val_d;
            seen_q        <= seen_d;
            bad_q         <= bad_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            blank_cnt_q   <= blank_cnt_d;
            blank_q       <= blank_d;
            blank_len_q   <= blank_len_d;
        end
    end

    assign val1        = val_q[0];
    assign val2        = val_q[1];
    assign val3        = val_q[2];
    assign val4        = val_q[3];
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign blank       = blank_q;
    assign blank_len   = blank_len_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: a vector table for the frame cases plus
// hand-written sequences for blanking and mid-frame reset.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  led_seg;
    logic        a1, a2, a3, a4;
    logic [3:0]  val1, val2, val3, val4;
    logic        frame_valid, frame_err, value_valid, blank;
    logic [13:0] value;
    logic [7:0]  blank_len;

    int n_tests = 0;
    int n_fail  = 0;

    seg_scan_decoder #(.BLANK_MIN(4), .BLANK_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .led_seg     (led_seg),
        .a1          (a1),
        .a2          (a2),
        .a3          (a3),
        .a4          (a4),
        .val1        (val1),
        .val2        (val2),
        .val3        (val3),
        .val4        (val4),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .value       (value),
        .value_valid (value_valid),
        .blank       (blank),
        .blank_len   (blank_len)
    );

    always #5 clk = ~clk;

    // Anode patterns as {a1,a2,a3,a4}, active-low.
    localparam logic [3:0] AN_1   = 4'b0111;
    localparam logic [3:0] AN_2   = 4'b1011;
    localparam logic [3:0] AN_3   = 4'b1101;
    localparam logic [3:0] AN_4   = 4'b1110;
    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_12  = 4'b0011;

    logic [6:0] seg_tab [10];
    localparam logic [6:0] SEG_BAD = 7'b1111111;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fv;
        logic        fe;
        logic [15:0] vals;   // {val1,val2,val3,val4}
        logic [13:0] value;
        logic        vv;
        logic        blank;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drive one sample, clock it in, and settle just after the edge.
    task automatic step(input logic [3:0] an, input logic [6:0] seg);
        {a1, a2, a3, a4} = an;
        led_seg = seg;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] vals_now();
        return {val1, val2, val3, val4};
    endfunction

    int fv_count;

    initial begin
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
        seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
        seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;

        // Frame 2345, then 2345 with a bad third digit, then a collision,
        // then a clean 0180 frame.
        vecs[0]  = '{AN_4,   seg_tab[5], 0, 0, 16'h0000, 14'd0,    0, 0};
        vecs[1]  = '{AN_3,   seg_tab[4], 0, 0, 16'h0000, 14'd0,    0, 0};
        vecs[2]  = '{AN_2,   seg_tab[3], 0, 0, 16'h0000, 14'd0,    0, 0};
        vecs[3]  = '{AN_1,   seg_tab[2], 1, 0, 16'h2345, 14'd0,    0, 0};
        vecs[4]  = '{AN_4,   seg_tab[5], 0, 0, 16'h2345, 14'd2345, 1, 0};
        vecs[5]  = '{AN_3,   seg_tab[4], 0, 0, 16'h2345, 14'd2345, 0, 0};
        vecs[6]  = '{AN_2,   SEG_BAD,    0, 0, 16'h2345, 14'd2345, 0, 0};
        vecs[7]  = '{AN_1,   seg_tab[2], 0, 1, 16'h2345, 14'd2345, 0, 0};
        vecs[8]  = '{AN_4,   seg_tab[0], 0, 0, 16'h2345, 14'd2345, 0, 0};
        vecs[9]  = '{AN_3,   seg_tab[8], 0, 0, 16'h2345, 14'd2345, 0, 0};
        vecs[10] = '{AN_12,  seg_tab[1], 0, 1, 16'h2345, 14'd2345, 0, 0};
        vecs[11] = '{AN_4,   seg_tab[0], 0, 0, 16'h2345, 14'd2345, 0, 0};
        vecs[12] = '{AN_3,   seg_tab[8], 0, 0, 16'h2345, 14'd2345, 0, 0};
        vecs[13] = '{AN_2,   seg_tab[1], 0, 0, 16'h2345, 14'd2345, 0, 0};
        vecs[14] = '{AN_1,   seg_tab[0], 1, 0, 16'h0180, 14'd2345, 0, 0};
        vecs[15] = '{AN_OFF, SEG_BAD,    0, 0, 16'h0180, 14'd180,  1, 0};

        // Reset with the display off.
        rst = 1'b1;
        step(AN_OFF, SEG_BAD);
        step(AN_OFF, SEG_BAD);
        check("reset_vals",      32'(vals_now()),  32'h0);
        check("reset_value",     32'(value),       32'd0);
        check("reset_pulses",    32'({frame_valid, frame_err, value_valid}), 32'd0);
        check("reset_blank",     32'(blank),       32'd0);
        check("reset_blank_len", 32'(blank_len),   32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].an, vecs[i].seg);
            check($sformatf("vec%0d_frame_valid", i), 32'(frame_valid), 32'(vecs[i].fv));
            check($sformatf("vec%0d_frame_err", i),   32'(frame_err),   32'(vecs[i].fe));
            check($sformatf("vec%0d_vals", i),        32'(vals_now()),  32'(vecs[i].vals));
            check($sformatf("vec%0d_value", i),       32'(value),       32'(vecs[i].value));
            check($sformatf("vec%0d_value_valid", i), 32'(value_valid), 32'(vecs[i].vv));
            check($sformatf("vec%0d_blank", i),       32'(blank),       32'(vecs[i].blank));
        end

        // Frame 0179 with a 50-cycle flash-off gap between digit 2 and digit 3.
        step(AN_4, seg_tab[9]);
        step(AN_3, seg_tab[7]);
        for (int k = 1; k <= 50; k++) begin
            step(AN_OFF, SEG_BAD);
            check($sformatf("gap_blank_k%0d", k), 32'(blank), 32'(k >= 4));
        end
        check("gap_blank_len_held", 32'(blank_len), 32'd0);
        step(AN_2, seg_tab[1]);
        check("gap_blank_fall",  32'(blank),       32'd0);
        check("gap_blank_len",   32'(blank_len),   32'd50);
        check("gap_no_pulse",    32'({frame_valid, frame_err}), 32'd0);
        step(AN_1, seg_tab[0]);
        check("gap_frame_valid", 32'(frame_valid), 32'd1);
        check("gap_vals",        32'(vals_now()),  32'h0179);
        step(AN_OFF, SEG_BAD);
        check("gap_value_valid", 32'(value_valid), 32'd1);
        check("gap_value",       32'(value),       32'd179);

        // Short gap below the threshold: blank never rises, length is kept.
        step(AN_OFF, SEG_BAD);
        check("short_blank_1", 32'(blank), 32'd0);
        step(AN_OFF, SEG_BAD);
        check("short_blank_2", 32'(blank), 32'd0);
        step(AN_4, seg_tab[6]);
        check("short_blank_3",   32'(blank),     32'd0);
        check("short_blank_len", 32'(blank_len), 32'd50);

        // Reset mid-frame, then a full 9999 frame.
        step(AN_3, seg_tab[6]);
        rst = 1'b1;
        step(AN_OFF, SEG_BAD);
        rst = 1'b0;
        check("midrst_vals",  32'(vals_now()), 32'h0);
        check("midrst_value", 32'(value),      32'd0);
        check("midrst_blank_len", 32'(blank_len), 32'd0);
        fv_count = 0;
        step(AN_4, seg_tab[9]);
        check("midrst_d1_fv", 32'(frame_valid), 32'd0);
        step(AN_3, seg_tab[9]);
        check("midrst_d2_fv", 32'(frame_valid), 32'd0);
        step(AN_2, seg_tab[9]);
        check("midrst_d3_fv", 32'(frame_valid), 32'd0);
        step(AN_1, seg_tab[9]);
        fv_count += int'(frame_valid);
        check("midrst_vals_9999", 32'(vals_now()), 32'h9999);
        step(AN_OFF, SEG_BAD);
        fv_count += int'(frame_valid);
        check("midrst_value_valid", 32'(value_valid), 32'd1);
        check("midrst_value",       32'(value),       32'd9999);
        step(AN_OFF, SEG_BAD);
        fv_count += int'(frame_valid);
        check("midrst_fv_count", 32'(fv_count), 32'd1);
        check("midrst_no_err",   32'(frame_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
